// File: rtl/spi_state_machine_pkg.sv
// Shared types and MCP3202 command constants for the SPI ADC reader.
package spi_state_machine_pkg;

  typedef enum logic [2:0] {
    StInit,
    StSetup,
    StTx,
    StRx,
    StDone,
    StIdle
  } state_e;

  localparam logic CmdStart = 1'b1;
  localparam logic CmdSgl   = 1'b1;
  localparam logic CmdMsbf  = 1'b1;

  localparam int unsigned DataWidth = 12;
  localparam int unsigned TxBits    = 4;
  localparam int unsigned RxBits    = 13;

  // Command nibble as shifted out, MSB first: START, SGL/DIFF, ODD/SIGN, MSBF.
  function automatic logic [TxBits-1:0] mcp_cmd(input logic odd);
    return {CmdStart, CmdSgl, odd, CmdMsbf};
  endfunction

endpackage

// File: rtl/spi_state_machine_sck_gen.sv
// SCK divider: SCK_HALF clocks high then SCK_HALF low while enabled, idle low otherwise.
// rise/fall/last flag the clock edge at which SCK rises, falls, or its period completes.
module spi_sck_gen #(
  parameter int unsigned SCK_HALF = 70
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall,
  output logic last
);

  localparam int unsigned CntW = $clog2(2 * SCK_HALF);

  logic [CntW-1:0] cnt;

  always_comb begin
    rise = en && (cnt == '0);
    fall = en && (cnt == CntW'(SCK_HALF));
    last = en && (cnt == CntW'(2 * SCK_HALF - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (rise) begin
        sck <= 1'b1;
      end else if (fall) begin
        sck <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_state_machine.sv
// Free-running MCP3202 SPI master (mode 0): command out, 12-bit sample in, one-clk valid strobe.
// Define SPI_SM_CH_ALTERNATE_EN to alternate the ODD/SIGN channel bit every frame.
module spi_state_machine
  import spi_state_machine_pkg::*;
#(
  parameter int unsigned SCK_HALF       = 70,
  parameter int unsigned INIT_CYCLES    = 2500,
  parameter int unsigned CS_HIGH_CYCLES = 1250,
  parameter int unsigned CHANNEL        = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MISO,
  output logic                 MOSI,
  output logic                 SCK,
  output logic [DataWidth-1:0] o_DATA,
  output logic                 CS,
  output logic                 DATA_VALID
);

  localparam int unsigned CntW = $clog2(INIT_CYCLES + CS_HIGH_CYCLES + SCK_HALF + 1);

  state_e               state;
  logic [CntW-1:0]      cnt;
  logic [3:0]           bit_cnt;
  logic [TxBits-1:0]    tx_sr;
  logic [DataWidth-1:0] rx_sr;
  logic                 odd;
  logic [TxBits-1:0]    cmd;

  logic sck_en, sck_rise, sck_fall, sck_last;

  assign sck_en = (state == StTx) || (state == StRx);
  assign cmd    = mcp_cmd(odd);

  spi_sck_gen #(
    .SCK_HALF(SCK_HALF)
  ) u_sck_gen (
    .clk (clk),
    .rst (rst),
    .en  (sck_en),
    .sck (SCK),
    .rise(sck_rise),
    .fall(sck_fall),
    .last(sck_last)
  );

  // SCK is registered inside the divider, so each strobe takes effect on the pins one
  // clock after the state that enables it; SETUP and DONE are shortened by one clock
  // in state terms to keep the pin-level SETUP and final SCK-low phases at SCK_HALF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StInit;
      cnt        <= '0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      odd        <= 1'(CHANNEL);
      CS         <= 1'b1;
      MOSI       <= 1'b0;
      o_DATA     <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      unique case (state)
        StInit: begin
          if (cnt == CntW'(INIT_CYCLES - 1)) begin
            cnt   <= '0;
            state <= StSetup;
            CS    <= 1'b0;
            tx_sr <= cmd;
            MOSI  <= cmd[TxBits-1];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StSetup: begin
          if (cnt == CntW'(SCK_HALF - 2)) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= StTx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StTx: begin
          // Shifting the command left leaves a trailing 0 on MOSI after the 4th fall.
          if (sck_fall) begin
            tx_sr <= {tx_sr[TxBits-2:0], 1'b0};
            MOSI  <= tx_sr[TxBits-2];
          end
          if (sck_last) begin
            if (bit_cnt == 4'(TxBits - 1)) begin
              bit_cnt <= '0;
              state   <= StRx;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        StRx: begin
          // The first sample is the ADC null bit and is not shifted in.
          if (sck_rise && (bit_cnt != '0)) begin
            rx_sr <= {rx_sr[DataWidth-2:0], MISO};
          end
          if (sck_last) begin
            if (bit_cnt == 4'(RxBits - 1)) begin
              bit_cnt <= '0;
              state   <= StDone;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        StDone: begin
          CS         <= 1'b1;
          o_DATA     <= rx_sr;
          DATA_VALID <= 1'b1;
          cnt        <= '0;
          state      <= StIdle;
`ifdef SPI_SM_CH_ALTERNATE_EN
          odd        <= ~odd;
`endif
        end
        StIdle: begin
          // CS already rose for the DONE clock, so wait one count longer here.
          if (cnt == CntW'(CS_HIGH_CYCLES)) begin
            cnt   <= '0;
            state <= StSetup;
            CS    <= 1'b0;
            tx_sr <= cmd;
            MOSI  <= cmd[TxBits-1];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= StInit;
          cnt   <= '0;
          CS    <= 1'b1;
          MOSI  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_state_machine.sv
// Self-checking bench for spi_state_machine: a behavioural MCP3202 drives MISO frame by frame.
module tb_spi_state_machine;

  localparam int unsigned SH   = 70;
  localparam int unsigned INIT = 2500;
  localparam int unsigned CSH  = 1250;
  localparam int unsigned CH   = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MISO = 1'b0;
  logic        MOSI, SCK, CS, DATA_VALID;
  logic [11:0] o_DATA;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned g_fall_cyc = 0;
  int unsigned g_rise_cyc = 0;
  bit          g_have_rise = 1'b0;
  logic [11:0] g_exp_data = '0;
  int unsigned frame_idx = 0;

  spi_state_machine #(
    .SCK_HALF      (SH),
    .INIT_CYCLES   (INIT),
    .CS_HIGH_CYCLES(CSH),
    .CHANNEL       (CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MISO      (MISO),
    .MOSI      (MOSI),
    .SCK       (SCK),
    .o_DATA    (o_DATA),
    .CS        (CS),
    .DATA_VALID(DATA_VALID)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic exp_odd();
    int unsigned c = CH;
`ifdef SPI_SM_CH_ALTERNATE_EN
    return c[0] ^ frame_idx[0];
`else
    return c[0];
`endif
  endfunction

  task automatic test_reset(input bit mid_rx);
    int n;
    int rises;
    logic prev_sck;
    bit sck_bad;
    if (mid_rx) begin
      n = 0;
      while (CS !== 1'b0 && n < 2 * INIT) begin
        @(negedge clk);
        n++;
      end
      rises = 0;
      prev_sck = SCK;
      while (rises < 8 && n < 4 * INIT) begin
        @(negedge clk);
        n++;
        MISO = 1'($urandom);
        if (SCK === 1'b1 && prev_sck === 1'b0) rises++;
        prev_sck = SCK;
      end
      checks++;
      if (rises != 8) begin
        errors++;
        $display("FAIL mid_rx_reach rises=%0d want 8", rises);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({CS, SCK, MOSI, DATA_VALID, o_DATA} !== {1'b1, 1'b0, 1'b0, 1'b0, 12'h000}) begin
        errors++;
        $display("FAIL mid_rx_async_reset cs=%b sck=%b mosi=%b valid=%b data=%h want 1 0 0 0 000",
                 CS, SCK, MOSI, DATA_VALID, o_DATA);
      end
    end else begin
      rst = 1'b1;
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({CS, SCK, MOSI, DATA_VALID, o_DATA} !== {1'b1, 1'b0, 1'b0, 1'b0, 12'h000}) begin
      errors++;
      $display("FAIL reset_values cs=%b sck=%b mosi=%b valid=%b data=%h want 1 0 0 0 000",
               CS, SCK, MOSI, DATA_VALID, o_DATA);
    end
    rst = 1'b0;
    n = 0;
    sck_bad = 1'b0;
    while (CS !== 1'b0 && n < INIT + 100) begin
      @(negedge clk);
      n++;
      MISO = 1'($urandom);
      if (SCK !== 1'b0 || DATA_VALID !== 1'b0) sck_bad = 1'b1;
    end
    checks++;
    if (n != INIT) begin
      errors++;
      $display("FAIL init_wait first_cs_fall_after=%0d want %0d", n, INIT);
    end
    checks++;
    if (sck_bad) begin
      errors++;
      $display("FAIL init_quiet sck_or_valid_active=1 want 0");
    end
    g_fall_cyc  = cyc;
    g_have_rise = 1'b0;
    g_exp_data  = '0;
    frame_idx   = 0;
  endtask

  task automatic run_frame(input logic [11:0] word, input logic null_bit, input string name);
    int   n;
    int   rises;
    int   falls;
    logic prev_sck, prev_mosi, fell;
    logic [3:0] cmd, want_cmd;
    bit   idle_bad, hold_bad, mosi_bad, rx_mosi_bad;
    idle_bad = 1'b0;
    n = 0;
    while (CS !== 1'b0 && n < 2 * (CSH + INIT)) begin
      @(negedge clk);
      n++;
      MISO = 1'($urandom);
      if (CS === 1'b1 && SCK !== 1'b0) idle_bad = 1'b1;
    end
    checks++;
    if (CS !== 1'b0) begin
      errors++;
      $display("FAIL %s cs_fall_timeout cs=%b want 0", name, CS);
      return;
    end
    if (n > 0) g_fall_cyc = cyc;
    checks++;
    if (idle_bad) begin
      errors++;
      $display("FAIL %s sck_while_cs_high got toggling want 0", name);
    end
    if (g_have_rise) begin
      checks++;
      if (g_fall_cyc - g_rise_cyc != 1 + CSH) begin
        errors++;
        $display("FAIL %s cs_high_gap=%0d want %0d", name, g_fall_cyc - g_rise_cyc, 1 + CSH);
      end
    end

    rises = 0;
    falls = 0;
    cmd = '0;
    hold_bad = 1'b0;
    mosi_bad = 1'b0;
    rx_mosi_bad = 1'b0;
    prev_sck = SCK;
    prev_mosi = MOSI;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (CS === 1'b0) begin
        fell = (SCK === 1'b0 && prev_sck === 1'b1);
        if (SCK === 1'b1 && prev_sck === 1'b0) begin
          if (rises < 4) cmd[3-rises] = MOSI;
          else if (MOSI !== 1'b0) rx_mosi_bad = 1'b1;
          rises++;
        end
        if (fell) begin
          falls++;
          // Bit presented for the next SCK rise: null bit, then the word MSB first.
          if (rises == 4) MISO = null_bit;
          else if (rises >= 5 && rises <= 16) MISO = word[16-rises];
          else MISO = 1'($urandom);
        end
        if (MOSI !== prev_mosi && !fell) mosi_bad = 1'b1;
        if (o_DATA !== g_exp_data || DATA_VALID !== 1'b0) hold_bad = 1'b1;
        prev_sck = SCK;
        prev_mosi = MOSI;
      end
    end while (CS === 1'b0 && n < 40 * SH);

    checks++;
    if (CS !== 1'b1) begin
      errors++;
      $display("FAIL %s cs_rise_timeout cs=%b want 1", name, CS);
      return;
    end
    g_rise_cyc = cyc;
    g_have_rise = 1'b1;
    want_cmd = {1'b1, 1'b1, exp_odd(), 1'b1};

    checks++;
    if (g_rise_cyc - g_fall_cyc != 35 * SH) begin
      errors++;
      $display("FAIL %s cs_low_len=%0d want %0d", name, g_rise_cyc - g_fall_cyc, 35 * SH);
    end
    checks++;
    if (rises != 17 || falls != 17) begin
      errors++;
      $display("FAIL %s sck_edges rises=%0d falls=%0d want 17 17", name, rises, falls);
    end
    checks++;
    if (cmd !== want_cmd) begin
      errors++;
      $display("FAIL %s mosi_cmd got=%b want=%b", name, cmd, want_cmd);
    end
    checks++;
    if (rx_mosi_bad || mosi_bad) begin
      errors++;
      $display("FAIL %s mosi_timing rx_nonzero=%0d off_fall_change=%0d want 0 0",
               name, rx_mosi_bad, mosi_bad);
    end
    checks++;
    if (hold_bad) begin
      errors++;
      $display("FAIL %s data_hold got change_or_strobe want data=%h valid=0", name, g_exp_data);
    end
    checks++;
    if (DATA_VALID !== 1'b1 || o_DATA !== word) begin
      errors++;
      $display("FAIL %s strobe valid=%b data=%h want 1 %h", name, DATA_VALID, o_DATA, word);
    end
    @(negedge clk);
    checks++;
    if (DATA_VALID !== 1'b0 || o_DATA !== word || CS !== 1'b1 || SCK !== 1'b0) begin
      errors++;
      $display("FAIL %s after_strobe valid=%b data=%h cs=%b sck=%b want 0 %h 1 0",
               name, DATA_VALID, o_DATA, CS, SCK, word);
    end
    g_exp_data = word;
    frame_idx++;
  endtask

  task automatic test_fixed_words();
    run_frame(12'hD73, 1'b1, "word_d73");
    run_frame(12'h003, 1'b1, "word_003");
  endtask

  task automatic test_random_words();
    for (int i = 0; i < 4; i++) begin
      run_frame(12'($urandom), 1'($urandom), "word_rand");
    end
  endtask

  task automatic test_reset_mid_rx();
    test_reset(1'b1);
    run_frame(12'($urandom), 1'($urandom), "after_reset");
  endtask

  initial begin
    test_reset(1'b0);
    test_fixed_words();
    test_random_words();
    test_reset_mid_rx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_state_machine.md
# spi_state_machine

SPI master that continuously drives an MCP3202 12-bit ADC: asserts CS, shifts out the 4-bit start/config command, shifts in the null bit plus 12 data bits MSB first, then publishes the sample with a one-cycle valid strobe. It sits between the board ADC pins and the sample-processing datapath. SPI mode 0 (SCK idles low), free-running with no request handshake.

## Interface
- SCK_HALF, 70: system clocks per SCK half-period (125 MHz clk gives about 893 kHz SCK).
- INIT_CYCLES, 2500: power-up wait after reset, before the first CS assertion.
- CS_HIGH_CYCLES, 1250: minimum CS-high (disable) time between conversions.
- CHANNEL, 0: ADC channel, used as the ODD/SIGN bit.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- MISO  in  1  ADC Dout; may be Z while CS is high, and is ignored outside the sampling points.
- MOSI  out  1  ADC Din.
- SCK  out  1  SPI clock.
- o_DATA  out  12  last completed conversion result.
- CS  out  1  ADC chip select, active-low.
- DATA_VALID  out  1  one-clk pulse when o_DATA updates.

## Operation
- Reset values: CS=1, SCK=0, MOSI=0, o_DATA=0, DATA_VALID=0, state INIT, all counters 0.
- State INIT: count INIT_CYCLES clocks, then go to SETUP.
- State SETUP: CS=0, SCK=0, MOSI=start bit 1. Hold for SCK_HALF clocks, then go to TX.
- State TX: 4 SCK cycles. Each cycle is SCK high for SCK_HALF clocks, then SCK low for SCK_HALF clocks.
  - MOSI per cycle: start=1, SGL/DIFF=1, ODD/SIGN=channel, MSBF=1.
  - MOSI changes only at SCK falling edges.
  - After the 4th cycle, MOSI=0 and go to RX.
- State RX: 13 SCK cycles. MISO is sampled in the clk in which SCK goes high.
  - Sample 1 is the null bit and is discarded.
  - Samples 2..13 shift into a 12-bit register MSB first (B11..B0).
- State DONE: after the 13th RX falling edge:
  - CS=1; o_DATA is loaded from the shift register.
  - DATA_VALID=1 for exactly one clk.
  - Go to IDLE.
- State IDLE: CS held high for CS_HIGH_CYCLES clocks, then go to SETUP. Conversions repeat forever.
- o_DATA holds its value between DONE strobes.
- Reset asserted mid-frame: all outputs return immediately to reset values, and the partial word is discarded.

## Timing
- Frame: SETUP (SCK_HALF clocks) + 17 SCK periods (2*SCK_HALF each) + 1 DONE clk.
- First CS fall occurs INIT_CYCLES clocks after reset release.
- DATA_VALID rises in the same cycle CS returns high; o_DATA is valid in that cycle.
- Conversion period: SCK_HALF*35 + 1 + CS_HIGH_CYCLES clocks.
- SCK never toggles while CS=1.

## Configuration
- Macro SPI_SM_CH_ALTERNATE_EN.
  - Defined: the ODD/SIGN bit toggles each frame, starting from CHANNEL, so frames alternate CH0/CH1.
  - Undefined: every frame uses CHANNEL.
- o_DATA carries no channel tag in either mode.

## Structure
- Shared package holds:
  - the state enum (INIT, SETUP, TX, RX, DONE, IDLE);
  - the MCP3202 command constants (START=1, SGL=1, MSBF=1);
  - the data width (12), TX bit count (4) and RX bit count (13).
- One sub-module: spi_sck_gen, a SCK_HALF divider producing SCK plus single-clk rise and fall strobes, enabled only in TX/RX.

## Test plan
- Reset, release, 125 MHz clk: CS stays 1 and SCK stays 0 for 2500 clks, then CS falls.
- Capture MOSI at SCK rising edges of the first 4 cycles: 1,1,0,1 (CHANNEL=0).
- Drive MISO null=1, then 1,1,0,1,0,1,1,1,0,0,1,1, each bit changing after SCK falling edge: o_DATA=0xD73, with a one-clk DATA_VALID coincident with CS rising.
- Next frame, MISO null=1, then 0x003 bits: o_DATA=0x003; o_DATA holds 0xD73 until that strobe.
- Assert rst mid-RX: CS=1, SCK=0, DATA_VALID=0 immediately; o_DATA=0; restart after INIT_CYCLES.
- With SPI_SM_CH_ALTERNATE_EN defined: the 3rd MOSI bit reads 0,1,0 over three frames; the CS-high gap is at least 1250 clks each time.
